// File: rtl/dram_multi_arbiter.sv
// dram_multi_arbiter
// Shares a single DRAM controller port between one write channel and
// NUM_RCH prefetching read channels. Each channel owns an address pointer
// that advances by ADDR_STEP per completed transfer. A channel is "pending"
// while its ready flag is low: the write channel after data is captured,
// a read channel after its prefetched word has been consumed or its
// pointer reloaded.
//
// Optional feature macro: DRAM_ARB_ROUND_ROBIN_EN
//   defined   -> rotating-priority grant starting at a rotation pointer
//   undefined -> fixed priority, write channel first, then read 0, 1, ...
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   wAddrLoad/wAddrIn   write pointer load
//   wWrite/wData        write request and data (captured when wReady=1)
//   wReady/wAddr        write channel idle flag, write pointer
//   rAddrLoad/rAddrIn   per-channel read pointer load (slice i = channel i)
//   rAck                per-channel consume strobe
//   rReady/rAddr/rData  per-channel valid flag, pointer, prefetched word
//   memReq/memWrite/memAddr/memWData   transaction to DRAM controller
//   memReady/memRData   single-cycle completion pulse and read data
module dram_multi_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_RCH    = 3,
    parameter int ADDR_STEP  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wAddrLoad,
    input  logic [ADDR_WIDTH-1:0]            wAddrIn,
    input  logic                             wWrite,
    input  logic [DATA_WIDTH-1:0]            wData,
    output logic                             wReady,
    output logic [ADDR_WIDTH-1:0]            wAddr,
    input  logic [NUM_RCH-1:0]               rAddrLoad,
    input  logic [NUM_RCH*ADDR_WIDTH-1:0]    rAddrIn,
    input  logic [NUM_RCH-1:0]               rAck,
    output logic [NUM_RCH-1:0]               rReady,
    output logic [NUM_RCH*ADDR_WIDTH-1:0]    rAddr,
    output logic [NUM_RCH*DATA_WIDTH-1:0]    rData,
    output logic                             memReq,
    output logic                             memWrite,
    input  logic                             memReady,
    output logic [ADDR_WIDTH-1:0]            memAddr,
    input  logic [DATA_WIDTH-1:0]            memRData,
    output logic [DATA_WIDTH-1:0]            memWData
);

    localparam int NUM_REQ = NUM_RCH + 1;
    localparam int IW      = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state_r, state_n;
    logic [IW-1:0]           grant_r, grant_n, grant_s;
    logic                    mem_req_r, mem_req_n;
    logic                    mem_write_r, mem_write_n;
    logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_n, sel_addr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_r, mem_wdata_n;

    logic                    w_ready_r;
    logic [ADDR_WIDTH-1:0]   w_addr_r;
    logic [DATA_WIDTH-1:0]   w_data_r;
    logic [NUM_RCH-1:0]      r_ready_r;
    logic [NUM_RCH-1:0]      stale_r;
    logic [ADDR_WIDTH-1:0]   r_addr_r [NUM_RCH];
    logic [DATA_WIDTH-1:0]   r_data_r [NUM_RCH];

    logic [NUM_REQ-1:0]      pending_s;
    logic                    any_pending_s;
    logic                    start_s;
    logic                    done_s;
    logic                    wr_done_s;
    logic [NUM_RCH-1:0]      rd_done_s;
    logic [NUM_RCH-1:0]      rd_busy_s;
    logic [NUM_RCH-1:0]      rd_start_s;

    assign pending_s     = {~r_ready_r, ~w_ready_r};
    assign any_pending_s = |pending_s;
    assign start_s       = (state_r == IDLE) && any_pending_s;
    // memReady outside BUSY is simply ignored
    assign done_s        = (state_r == BUSY) && memReady;
    assign wr_done_s     = done_s && (grant_r == IW'(0));

    // Per-read-channel grant/completion decode
    always_comb begin
        rd_done_s  = '0;
        rd_busy_s  = '0;
        rd_start_s = '0;
        for (int i = 0; i < NUM_RCH; i++) begin
            rd_busy_s[i]  = (state_r == BUSY) && (grant_r == IW'(i + 1));
            rd_done_s[i]  = rd_busy_s[i] && memReady;
            rd_start_s[i] = start_s && (grant_s == IW'(i + 1));
        end
    end

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    localparam logic [IW:0] NUM_REQ_W = (IW + 1)'(NUM_REQ);

    logic [IW-1:0]          rr_ptr_r;
    logic [IW-1:0]          rr_next_s;
    logic [IW-1:0]          rr_off_s;
    logic [IW:0]            rr_sum_s;
    logic [IW:0]            rr_inc_s;
    logic [2*NUM_REQ-1:0]   rr_rot_s;

    // Rotating grant: rotate pending so the pointer lands at bit 0, take the
    // lowest set bit, then rotate the offset back to a requester index
    always_comb begin
        rr_rot_s = {pending_s, pending_s} >> rr_ptr_r;
        rr_off_s = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rr_rot_s[j]) begin
                rr_off_s = IW'(j);
            end else begin
                rr_off_s = rr_off_s;
            end
        end
        rr_sum_s = {1'b0, rr_ptr_r} + {1'b0, rr_off_s};
        if (rr_sum_s >= NUM_REQ_W) begin
            rr_sum_s = rr_sum_s - NUM_REQ_W;
        end else begin
            rr_sum_s = rr_sum_s;
        end
        grant_s  = rr_sum_s[IW-1:0];
        rr_inc_s = {1'b0, grant_s} + {{IW{1'b0}}, 1'b1};
        if (rr_inc_s == NUM_REQ_W) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = rr_inc_s[IW-1:0];
        end
    end

    // Rotation pointer moves past the winner on every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (start_s) begin
            rr_ptr_r <= rr_next_s;
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest pending index
    always_comb begin
        grant_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending_s[i]) begin
                grant_s = IW'(i);
            end else begin
                grant_s = grant_s;
            end
        end
    end
`endif

    // Address of the candidate winner
    always_comb begin
        sel_addr_s = w_addr_r;
        for (int i = 0; i < NUM_RCH; i++) begin
            if (grant_s == IW'(i + 1)) begin
                sel_addr_s = r_addr_r[i];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // FSM next state and transaction register next values
    always_comb begin
        state_n     = state_r;
        grant_n     = grant_r;
        mem_req_n   = mem_req_r;
        mem_write_n = mem_write_r;
        mem_addr_n  = mem_addr_r;
        mem_wdata_n = mem_wdata_r;
        case (state_r)
            IDLE: begin
                if (any_pending_s) begin
                    state_n     = BUSY;
                    grant_n     = grant_s;
                    mem_req_n   = 1'b1;
                    mem_write_n = (grant_s == IW'(0));
                    mem_addr_n  = sel_addr_s;
                    mem_wdata_n = w_data_r;
                end else begin
                    mem_req_n   = 1'b0;
                end
            end
            BUSY: begin
                if (memReady) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                end else begin
                    mem_req_n = 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

    // FSM state and transaction registers (held stable through BUSY)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            mem_req_r   <= mem_req_n;
            mem_write_r <= mem_write_n;
            mem_addr_r  <= mem_addr_n;
            mem_wdata_r <= mem_wdata_n;
        end
    end

    // Write channel: capture, completion, pointer (a load beats the increment)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ready_r <= 1'b1;
            w_addr_r  <= '0;
            w_data_r  <= '0;
        end else begin
            if (wr_done_s) begin
                w_ready_r <= 1'b1;
            end else if (wWrite && w_ready_r) begin
                w_ready_r <= 1'b0;
                w_data_r  <= wData;
            end
            if (wAddrLoad) begin
                w_addr_r <= wAddrIn;
            end else if (wr_done_s) begin
                w_addr_r <= w_addr_r + STEP;
            end
        end
    end

    // Read channels: a reload wins over ack and over an arriving word; a
    // reload while the channel's fetch is in flight marks that fetch stale
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready_r <= '1;
            stale_r   <= '0;
            for (int i = 0; i < NUM_RCH; i++) begin
                r_addr_r[i] <= '0;
                r_data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RCH; i++) begin
                if (rAddrLoad[i]) begin
                    r_addr_r[i]  <= rAddrIn[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_ready_r[i] <= 1'b0;
                end else if (rAck[i] && r_ready_r[i]) begin
                    r_addr_r[i]  <= r_addr_r[i] + STEP;
                    r_ready_r[i] <= 1'b0;
                end else if (rd_done_s[i] && !stale_r[i]) begin
                    r_data_r[i]  <= memRData;
                    r_ready_r[i] <= 1'b1;
                end
                if (rd_done_s[i]) begin
                    stale_r[i] <= 1'b0;
                end else if (rAddrLoad[i] && (rd_busy_s[i] || rd_start_s[i])) begin
                    stale_r[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RCH; g++) begin : g_pack
        assign rAddr[g*ADDR_WIDTH +: ADDR_WIDTH] = r_addr_r[g];
        assign rData[g*DATA_WIDTH +: DATA_WIDTH] = r_data_r[g];
    end

    assign wReady   = w_ready_r;
    assign wAddr    = w_addr_r;
    assign rReady   = r_ready_r;
    assign memReq   = mem_req_r;
    assign memWrite = mem_write_r;
    assign memAddr  = mem_addr_r;
    assign memWData = mem_wdata_r;

endmodule

// File: tb/tb_dram_multi_arbiter.sv
// Directed bench for dram_multi_arbiter. Expected DRAM transactions are
// queued when stimulus is applied and compared when memReq appears.
module tb_dram_multi_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int NR = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 wAddrLoad = 1'b0;
    logic [AW-1:0]        wAddrIn = '0;
    logic                 wWrite = 1'b0;
    logic [DW-1:0]        wData = '0;
    logic                 wReady;
    logic [AW-1:0]        wAddr;
    logic [NR-1:0]        rAddrLoad = '0;
    logic [NR*AW-1:0]     rAddrIn = '0;
    logic [NR-1:0]        rAck = '0;
    logic [NR-1:0]        rReady;
    logic [NR*AW-1:0]     rAddr;
    logic [NR*DW-1:0]     rData;
    logic                 memReq;
    logic                 memWrite;
    logic                 memReady = 1'b0;
    logic [AW-1:0]        memAddr;
    logic [DW-1:0]        memRData = '0;
    logic [DW-1:0]        memWData;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    dram_multi_arbiter dut (
        .clk(clk), .reset(reset),
        .wAddrLoad(wAddrLoad), .wAddrIn(wAddrIn), .wWrite(wWrite), .wData(wData),
        .wReady(wReady), .wAddr(wAddr),
        .rAddrLoad(rAddrLoad), .rAddrIn(rAddrIn), .rAck(rAck),
        .rReady(rReady), .rAddr(rAddr), .rData(rData),
        .memReq(memReq), .memWrite(memWrite), .memReady(memReady),
        .memAddr(memAddr), .memRData(memRData), .memWData(memWData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] raddr(input int i);
        return rAddr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] rdat(input int i);
        return rData[i*DW +: DW];
    endfunction

    task automatic push(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
        txn_t t;
        t.addr = a; t.wr = wr; t.wdata = d;
        exp_q.push_back(t);
    endtask

    // Wait (bounded) for memReq, then compare against the scoreboard head
    task automatic take();
        int   w;
        txn_t t;
        w = 0;
        while (memReq !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk("memreq_seen", memReq, 1);
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("mem_addr", memAddr, t.addr);
            chk("mem_write", memWrite, t.wr);
            if (t.wr) chk("mem_wdata", memWData, t.wdata);
        end
    endtask

    // Hold BUSY for lat cycles, then pulse memReady with data d
    task automatic complete(input logic [DW-1:0] d, input int lat);
        logic [AW-1:0] a;
        a = memAddr;
        repeat (lat) tick();
        chk("addr_stable", memAddr, a);
        chk("req_held", memReq, 1);
        memReady = 1'b1;
        memRData = d;
        tick();
        memReady = 1'b0;
        memRData = '0;
        chk("req_drop", memReq, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wAddrLoad = 1'b0; wWrite = 1'b0; rAddrLoad = '0; rAck = '0; memReady = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_wready", wReady, 1);
        chk("rst_rready", rReady, 3'b111);
        chk("rst_memreq", memReq, 0);
        chk("rst_memwrite", memWrite, 0);
        chk("rst_memaddr", memAddr, 0);
        chk("rst_memwdata", memWData, 0);
        chk("rst_waddr", wAddr, 0);
        chk("rst_raddr", rAddr, 0);
        chk("rst_rdata", rData, 0);

        // Write 0xBEEF at 0x00100; a second wWrite while busy is ignored
        wAddrLoad = 1'b1; wAddrIn = 20'h00100;
        tick();
        wAddrLoad = 1'b0;
        chk("waddr_load", wAddr, 20'h00100);
        wWrite = 1'b1; wData = 16'hBEEF;
        push(20'h00100, 1'b1, 16'hBEEF);
        tick();
        chk("wready_clr", wReady, 0);
        chk("req_latency0", memReq, 0);
        wData = 16'h1111;
        tick();
        wWrite = 1'b0;
        chk("req_latency1", memReq, 1);
        take();
        complete(16'h0000, 2);
        chk("wready_set", wReady, 1);
        chk("waddr_inc", wAddr, 20'h00101);

        // Read channel 1 at 0x00040, consume, next prefetch at 0x00041
        rAddrLoad = 3'b010; rAddrIn = {20'h0, 20'h00040, 20'h0};
        tick();
        rAddrLoad = '0;
        chk("r1_load_clr", rReady[1], 0);
        push(20'h00040, 1'b0, 16'h0);
        take();
        complete(16'h1234, 1);
        chk("r1_ready", rReady[1], 1);
        chk("r1_data", rdat(1), 16'h1234);
        rAck = 3'b010;
        tick();
        chk("r1_ack_addr", raddr(1), 20'h00041);
        chk("r1_ack_clr", rReady[1], 0);
        push(20'h00041, 1'b0, 16'h0);
        tick();
        rAck = '0;
        chk("r1_ack_ignored", raddr(1), 20'h00041);
        take();
        complete(16'h5678, 0);
        chk("r1_data2", rdat(1), 16'h5678);

        // Reload channel 0 while its fetch of 0x00010 is in flight
        rAddrLoad = 3'b001; rAddrIn = {20'h0, 20'h0, 20'h00010};
        tick();
        rAddrLoad = '0;
        push(20'h00010, 1'b0, 16'h0);
        take();
        rAddrLoad = 3'b001; rAddrIn = {20'h0, 20'h0, 20'h00200};
        tick();
        rAddrLoad = '0;
        chk("r0_reload", raddr(0), 20'h00200);
        memReady = 1'b1; memRData = 16'hDEAD;
        tick();
        memReady = 1'b0;
        chk("stale_req_drop", memReq, 0);
        chk("stale_rready", rReady[0], 0);
        chk("stale_rdata", rdat(0), 16'h0000);
        push(20'h00200, 1'b0, 16'h0);
        take();
        complete(16'hCAFE, 1);
        chk("r0_data", rdat(0), 16'hCAFE);
        chk("r0_ready", rReady[0], 1);

        // Channel 2 pointer wrap from all-ones
        rAddrLoad = 3'b100; rAddrIn = {20'hFFFFF, 20'h0, 20'h0};
        tick();
        rAddrLoad = '0;
        push(20'hFFFFF, 1'b0, 16'h0);
        take();
        complete(16'h0F0F, 0);
        chk("r2_ready", rReady[2], 1);
        chk("r2_data", rdat(2), 16'h0F0F);
        rAck = 3'b100;
        tick();
        rAck = '0;
        chk("r2_wrap", raddr(2), 20'h00000);
        push(20'h00000, 1'b0, 16'h0);
        take();
        complete(16'h2222, 0);
        chk("r2_data2", rdat(2), 16'h2222);

        // wAddrLoad on the completion cycle of a write: load wins, no increment
        wWrite = 1'b1; wData = 16'h7777;
        push(20'h00101, 1'b1, 16'h7777);
        tick();
        wWrite = 1'b0;
        take();
        memReady = 1'b1; wAddrLoad = 1'b1; wAddrIn = 20'h00300;
        tick();
        memReady = 1'b0; wAddrLoad = 1'b0;
        chk("wload_win", wAddr, 20'h00300);
        chk("wload_ready", wReady, 1);

        // Arbitration with every requester pending; write re-armed after its grant
        do_reset();
        rAddrLoad = 3'b111; rAddrIn = {20'h00030, 20'h00020, 20'h00010};
        wWrite = 1'b1; wData = 16'hAAAA;
        tick();
        rAddrLoad = '0; wWrite = 1'b0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        push(20'h00000, 1'b1, 16'hAAAA);
        push(20'h00010, 1'b0, 16'h0);
        push(20'h00020, 1'b0, 16'h0);
        push(20'h00030, 1'b0, 16'h0);
        push(20'h00001, 1'b1, 16'hBBBB);
`else
        push(20'h00000, 1'b1, 16'hAAAA);
        push(20'h00010, 1'b0, 16'h0);
        push(20'h00001, 1'b1, 16'hBBBB);
        push(20'h00020, 1'b0, 16'h0);
        push(20'h00030, 1'b0, 16'h0);
`endif
        take();
        complete(16'h0000, 0);
        chk("arb_wready", wReady, 1);
        wWrite = 1'b1; wData = 16'hBBBB;
        tick();
        wWrite = 1'b0;
        for (int k = 0; k < 4; k++) begin
            take();
            complete(memAddr[DW-1:0] ^ 16'h5A5A, 0);
        end
        chk("arb_r0_data", rdat(0), 16'h5A4A);
        chk("arb_r1_data", rdat(1), 16'h5A7A);
        chk("arb_r2_data", rdat(2), 16'h5A6A);
        chk("arb_ready", {wReady, rReady}, 4'b1111);

        // Reset in the middle of a transaction, then a stray memReady
        rAck = 3'b001;
        tick();
        rAck = '0;
        push(20'h00011, 1'b0, 16'h0);
        take();
        reset = 1'b1;
        #1;
        chk("async_req_drop", memReq, 0);
        chk("async_wready", wReady, 1);
        chk("async_rready", rReady, 3'b111);
        #1;
        reset = 1'b0;
        memReady = 1'b1; memRData = 16'hFFFF;
        tick();
        memReady = 1'b0;
        chk("stray_req", memReq, 0);
        chk("stray_rready", rReady, 3'b111);
        chk("stray_rdata", rData, 0);
        chk("stray_raddr", rAddr, 0);
        tick();
        chk("stray_req2", memReq, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
